// File: rtl/sysahb_master_if.sv
// Command/response and AHB-Lite bus signals of the sysahb initiator.
// The master modport is the initiator's view; slave is the opposite side (bus fabric / requester).
interface sysahb_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] sysahb_haddr;
  logic [1:0]  sysahb_htrans;
  logic        sysahb_hwrite;
  logic [2:0]  sysahb_hsize;
  logic [2:0]  sysahb_hburst;
  logic [3:0]  sysahb_hprot;
  logic [31:0] sysahb_hwdata;
  logic        sysahb_hready;
  logic        sysahb_hresp;
  logic [31:0] sysahb_hrdata;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output sysahb_haddr, sysahb_htrans, sysahb_hwrite, sysahb_hsize,
    output sysahb_hburst, sysahb_hprot, sysahb_hwdata,
    input  sysahb_hready, sysahb_hresp, sysahb_hrdata
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  sysahb_haddr, sysahb_htrans, sysahb_hwrite, sysahb_hsize,
    input  sysahb_hburst, sysahb_hprot, sysahb_hwdata,
    output sysahb_hready, sysahb_hresp, sysahb_hrdata
  );
endinterface

// File: rtl/sysahb_master.sv
// AHB-Lite initiator: turns commands into single NONSEQ transfers with a two-stage
// (address / data) pipeline, wait-state handling and the two-cycle ERROR response.
module sysahb_master #(
  parameter logic [3:0] HPROT_VAL  = 4'b0011,
  parameter bit         ERR_CANCEL = 1'b1
) (
  input logic             sys_clk,
  input logic             sys_reset,
  sysahb_master_if.master bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic        a_full_q, a_full_d;
  logic        a_cancel_q, a_cancel_d;
  logic [31:0] a_addr_q, a_addr_d;
  logic        a_write_q, a_write_d;
  logic [1:0]  a_size_q, a_size_d;
  logic [31:0] a_wdata_q, a_wdata_d;
  logic        d_full_q, d_full_d;
  logic        d_write_q, d_write_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic a_nonseq, cmd_ready, accept, a_go, d_done;

  always_comb begin
    a_nonseq  = a_full_q && !a_cancel_q;
    cmd_ready = !a_full_q || (bus.sysahb_hready && a_nonseq);
    accept    = bus.cmd_valid && cmd_ready;
    a_go      = a_nonseq && bus.sysahb_hready;
    d_done    = d_full_q && bus.sysahb_hready;

    a_full_d  = accept || (a_full_q && !a_go);
    a_addr_d  = a_addr_q;
    a_write_d = a_write_q;
    a_size_d  = a_size_q;
    a_wdata_d = a_wdata_q;
    if (accept) begin
      a_addr_d  = bus.cmd_addr;
      a_write_d = bus.cmd_write;
      a_size_d  = bus.cmd_size;
      a_wdata_d = bus.cmd_wdata;
    end

    // First ERROR cycle retracts the pending address phase; it is re-driven once HREADY returns.
    a_cancel_d = a_cancel_q;
    if (bus.sysahb_hready)
      a_cancel_d = 1'b0;
    else if (ERR_CANCEL && bus.sysahb_hresp && d_full_q && a_full_q)
      a_cancel_d = 1'b1;

    d_full_d  = a_go || (d_full_q && !bus.sysahb_hready);
    d_write_d = d_write_q;
    d_wdata_d = d_wdata_q;
    if (a_go) begin
      d_write_d = a_write_q;
      d_wdata_d = a_wdata_q;
    end

    rsp_valid_d = d_done;
    rsp_err_d   = d_done && bus.sysahb_hresp;
    rsp_rdata_d = (d_done && !d_write_q) ? bus.sysahb_hrdata : 32'h0;
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      a_full_q    <= 1'b0;
      a_cancel_q  <= 1'b0;
      a_addr_q    <= 32'h0;
      a_write_q   <= 1'b0;
      a_size_q    <= 2'b00;
      a_wdata_q   <= 32'h0;
      d_full_q    <= 1'b0;
      d_write_q   <= 1'b0;
      d_wdata_q   <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      a_full_q    <= a_full_d;
      a_cancel_q  <= a_cancel_d;
      a_addr_q    <= a_addr_d;
      a_write_q   <= a_write_d;
      a_size_q    <= a_size_d;
      a_wdata_q   <= a_wdata_d;
      d_full_q    <= d_full_d;
      d_write_q   <= d_write_d;
      d_wdata_q   <= d_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready     = cmd_ready;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.sysahb_htrans = a_nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.sysahb_haddr  = a_addr_q;
  assign bus.sysahb_hwrite = a_write_q;
  assign bus.sysahb_hsize  = {1'b0, a_size_q};
  assign bus.sysahb_hburst = 3'b000;
  assign bus.sysahb_hprot  = HPROT_VAL;
  assign bus.sysahb_hwdata = d_wdata_q;

endmodule
